// File: rtl/pulse_stretch_led.sv
// Stretches single-cycle event pulses into visible LED blinks (ON_CYCLES high, OFF_CYCLES low),
// queueing events that arrive mid-blink in a saturating counter and replaying them in order.
module pulse_stretch_led #(
  parameter int CNT_W      = 16,
  parameter int ON_CYCLES  = 65535,
  parameter int OFF_CYCLES = 65535,
  parameter int QUEUE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse_in,
  input  logic               clr_ovf,
  output logic               led_out,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [QUEUE_W-1:0] PEND_ONE  = QUEUE_W'(1'b1);
  localparam logic [QUEUE_W-1:0] PEND_MAX  = {QUEUE_W{1'b1}};
  localparam logic [QUEUE_W-1:0] PEND_ZERO = {QUEUE_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               led_r, led_s;
  logic               busy_r, busy_s;
  logic [QUEUE_W-1:0] pend_r, pend_s;
  logic               ovf_r, ovf_s;
  logic               start_s, from_q_s, inc_s, dec_s, ovf_set_s, avail_s;

  // Next-state, timer, queue and sticky-overflow computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    led_s     = led_r;
    pend_s    = pend_r;
    ovf_s     = ovf_r;
    start_s   = 1'b0;
    from_q_s  = 1'b0;
    inc_s     = 1'b0;
    dec_s     = 1'b0;
    ovf_set_s = 1'b0;
    avail_s   = pulse_in || (pend_r != PEND_ZERO);

    case (state_r)
      ST_IDLE: begin
        if (avail_s) begin
          start_s = 1'b1;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      ST_ON: begin
        if (cnt_r == ON_LAST) begin
          state_s = ST_OFF;
          cnt_s   = CNT_ZERO;
          led_s   = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_OFF: begin
        // A waiting event restarts straight from the last OFF cycle so the gap stays exact.
        if (cnt_r == OFF_LAST) begin
          if (avail_s) begin
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        led_s   = 1'b0;
      end
    endcase

    if (start_s) begin
      state_s  = ST_ON;
      cnt_s    = CNT_ZERO;
      led_s    = 1'b1;
      from_q_s = (pend_r != PEND_ZERO);
    end else begin
      from_q_s = 1'b0;
    end

    // A pulse is queued unless it directly fed a start this cycle.
    inc_s = pulse_in && !(start_s && !from_q_s);
    dec_s = start_s && from_q_s;

    if (inc_s && !dec_s) begin
      if (pend_r != PEND_MAX) begin
        pend_s = pend_r + PEND_ONE;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (dec_s && !inc_s) begin
      pend_s = pend_r - PEND_ONE;
    end else begin
      pend_s = pend_r;
    end

    if (ovf_set_s) begin
      ovf_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
      pend_r  <= PEND_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      led_r   <= led_s;
      busy_r  <= busy_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
    end
  end

  assign led_out  = led_r;
  assign busy     = busy_r;
  assign pending  = pend_r;
  assign overflow = ovf_r;

endmodule
